downstream_cancel_tracker: RTL and testbench

Per-client cancelled-volume tracker that feeds the `cancelled_orders` input of the upstream risk-check processor. It accepts cancel events through a valid/ready handshake into a small FIFO and accumulates them into a per-client table with saturating arithmetic. It answers one-cycle-latency lookups keyed by `client_id`, so the risk check can compute `max_to_trade > accumulated + amount - cancelled`. After reset, and on request, the table is zeroed by a hardware sweep.

---
 rtl/downstream_cancel_tracker_if.sv | 30 +++
 rtl/downstream_cancel_tracker.sv | 85 ++++++++
 tb/tb_downstream_cancel_tracker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/downstream_cancel_tracker_if.sv
// downstream_cancel_tracker_if: cancel ingress, clear, lookup and status signals of the cancel tracker
interface downstream_cancel_tracker_if #(
   parameter int CID_W = 5,
   parameter int AMT_W = 16,
   parameter int CNT_W = 32
);
   logic             cancel_valid;
   logic             cancel_ready;
   logic [CID_W-1:0] cancel_client_id;
   logic [AMT_W-1:0] cancel_amount;
   logic             clear_valid;
   logic [CID_W-1:0] clear_client_id;
   logic             clear_all;
   logic             lookup_valid;
   logic [CID_W-1:0] lookup_client_id;
   logic [CNT_W-1:0] cancelled_orders;
   logic             lookup_done;
   logic             init_busy;
   logic             sat_flag;
   modport master (
      output cancel_valid, cancel_client_id, cancel_amount, clear_valid, clear_client_id,
             clear_all, lookup_valid, lookup_client_id,
      input  cancel_ready, cancelled_orders, lookup_done, init_busy, sat_flag
   );
   modport slave (
      input  cancel_valid, cancel_client_id, cancel_amount, clear_valid, clear_client_id,
             clear_all, lookup_valid, lookup_client_id,
      output cancel_ready, cancelled_orders, lookup_done, init_busy, sat_flag
   );
endinterface

// File: rtl/downstream_cancel_tracker.sv
// downstream_cancel_tracker: per-client saturating cancelled-volume table fed by a cancel FIFO, with write-first lookups
module downstream_cancel_tracker #(
   parameter int NUM_CLIENTS = 32,
   parameter int CID_W       = 5,
   parameter int AMT_W       = 16,
   parameter int CNT_W       = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input logic                        clk,
   input logic                        HRESETn,
   downstream_cancel_tracker_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   typedef enum logic {INIT, RUN} state_e;
   state_e           state_q, state_d;
   logic [CID_W-1:0] idx_q, idx_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic             sat_q, sat_d, done_q, done_d;
   logic [CNT_W-1:0] res_q, res_d;
   logic [CID_W-1:0] fid_q [FIFO_DEPTH];
   logic [AMT_W-1:0] famt_q [FIFO_DEPTH];
   logic [CNT_W-1:0] tbl_q [NUM_CLIENTS];
   logic             push, pop, wr_en;
   logic [CID_W-1:0] wr_addr;
   logic [CNT_W-1:0] wr_data;
   logic [CNT_W:0]   sum;
   assign bus.cancel_ready     = state_q == RUN && count_q < CW'(FIFO_DEPTH);
   assign bus.cancelled_orders = res_q;
   assign bus.lookup_done      = done_q;
   assign bus.init_busy        = state_q == INIT;
   assign bus.sat_flag         = sat_q;
   // Single table write port: sweep zeroing, then clear, then FIFO-head accumulate; lookup bypasses this write
   always_comb begin
      push    = bus.cancel_valid && bus.cancel_ready;
      pop     = state_q == RUN && !bus.clear_valid && count_q != '0;
      sum     = {1'b0, tbl_q[fid_q[rd_q]]} + (CNT_W+1)'(famt_q[rd_q]);
      wr_en   = state_q == INIT || bus.clear_valid || pop;
      wr_addr = state_q == INIT ? idx_q : bus.clear_valid ? bus.clear_client_id : fid_q[rd_q];
      wr_data = (state_q == INIT || bus.clear_valid) ? '0 : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      sat_d   = bus.clear_all ? 1'b0 : sat_q | (pop && sum[CNT_W]);
      count_d = bus.clear_all ? '0 : count_q + CW'(push) - CW'(pop);
      wr_d    = bus.clear_all ? '0 : wr_q + PW'(push);
      rd_d    = bus.clear_all ? '0 : rd_q + PW'(pop);
      state_d = bus.clear_all ? INIT : (state_q == INIT && idx_q == CID_W'(NUM_CLIENTS - 1)) ? RUN : state_q;
      idx_d   = bus.clear_all ? '0 : state_q == INIT ? idx_q + CID_W'(1) : idx_q;
      done_d  = bus.lookup_valid;
      res_d   = !bus.lookup_valid ? res_q : state_q == INIT ? '0 :
                (wr_en && wr_addr == bus.lookup_client_id) ? wr_data : tbl_q[bus.lookup_client_id];
   end
   // Control state, FIFO pointers and lookup result registers
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= INIT;
         idx_q   <= '0;
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
         res_q   <= res_d;
      end
   end
   // FIFO storage needs no reset; count and pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         fid_q[wr_q]  <= bus.cancel_client_id;
         famt_q[wr_q] <= bus.cancel_amount;
      end
   end
   // Table storage is zeroed by the INIT sweep rather than by reset
   always_ff @(posedge clk) begin
      if (wr_en) tbl_q[wr_addr] <= wr_data;
   end
endmodule

// File: tb/tb_downstream_cancel_tracker.sv
// tb_downstream_cancel_tracker: directed scoreboard bench for the cancel tracker
module tb_downstream_cancel_tracker;
   logic clk;
   logic HRESETn;
   int   n_cmp;
   int   n_err;
   logic [31:0] exp_q[$];
   downstream_cancel_tracker_if #(.CID_W(5), .AMT_W(16), .CNT_W(32)) bus ();
   downstream_cancel_tracker #(
      .NUM_CLIENTS(32), .CID_W(5), .AMT_W(16), .CNT_W(32), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .HRESETn(HRESETn),
      .bus(bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic lk(input logic [4:0] id, input logic [31:0] e);
      bus.lookup_valid     = 1'b1;
      bus.lookup_client_id = id;
      exp_q.push_back(e);
   endtask
   task automatic cxl(input logic [4:0] id, input logic [15:0] a);
      bus.cancel_valid     = 1'b1;
      bus.cancel_client_id = id;
      bus.cancel_amount    = a;
   endtask
   task automatic tick();
      logic lv;
      logic [31:0] e;
      lv = bus.lookup_valid;
      @(posedge clk);
      #1;
      chk("lookup_done", {31'b0, bus.lookup_done}, {31'b0, lv});
      if (lv) begin
         e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
         chk("lookup_data", bus.cancelled_orders, e);
      end
      bus.lookup_valid = 1'b0;
      bus.clear_valid  = 1'b0;
      bus.clear_all    = 1'b0;
   endtask
   initial begin
      n_cmp = 0;
      n_err = 0;
      HRESETn              = 1'b0;
      bus.cancel_valid     = 1'b0;
      bus.cancel_client_id = '0;
      bus.cancel_amount    = '0;
      bus.clear_valid      = 1'b0;
      bus.clear_client_id  = '0;
      bus.clear_all        = 1'b0;
      bus.lookup_valid     = 1'b0;
      bus.lookup_client_id = '0;
      tick();
      tick();
      chk("rst_ready", {31'b0, bus.cancel_ready}, 32'd0);
      chk("rst_orders", bus.cancelled_orders, 32'd0);
      chk("rst_busy", {31'b0, bus.init_busy}, 32'd1);
      chk("rst_sat", {31'b0, bus.sat_flag}, 32'd0);
      // reset sweep with a cancel held pending
      HRESETn = 1'b1;
      cxl(5'd3, 16'd10);
      for (int i = 0; i < 32; i++) begin
         chk("init_busy", {31'b0, bus.init_busy}, 32'd1);
         chk("init_ready", {31'b0, bus.cancel_ready}, 32'd0);
         if (i == 5) lk(5'd3, 32'd0);
         tick();
      end
      chk("run_busy", {31'b0, bus.init_busy}, 32'd0);
      chk("run_ready", {31'b0, bus.cancel_ready}, 32'd1);
      tick();
      bus.cancel_valid = 1'b0;
      lk(5'd3, 32'd10);
      tick();
      // accumulate with write-first bypass
      cxl(5'd7, 16'd100);
      lk(5'd7, 32'd0);
      tick();
      cxl(5'd7, 16'd250);
      lk(5'd7, 32'd100);
      tick();
      bus.cancel_valid = 1'b0;
      lk(5'd7, 32'd350);
      tick();
      // backpressure: clears block pops while five cancels arrive
      for (int i = 0; i < 4; i++) begin
         chk("bp_ready_open", {31'b0, bus.cancel_ready}, 32'd1);
         bus.clear_valid     = 1'b1;
         bus.clear_client_id = 5'd20;
         cxl(5'd11, 16'(1 << i));
         tick();
      end
      chk("bp_ready_full", {31'b0, bus.cancel_ready}, 32'd0);
      cxl(5'd11, 16'd16);
      lk(5'd11, 32'd1);
      tick();
      chk("bp_ready_reopen", {31'b0, bus.cancel_ready}, 32'd1);
      lk(5'd11, 32'd3);
      tick();
      bus.cancel_valid = 1'b0;
      lk(5'd11, 32'd7);
      tick();
      lk(5'd11, 32'd15);
      tick();
      lk(5'd11, 32'd31);
      tick();
      // clear wins over a pending pop of the same entry
      cxl(5'd2, 16'd40);
      tick();
      bus.cancel_valid = 1'b0;
      tick();
      cxl(5'd2, 16'd5);
      lk(5'd2, 32'd40);
      tick();
      bus.cancel_valid    = 1'b0;
      bus.clear_valid     = 1'b1;
      bus.clear_client_id = 5'd2;
      lk(5'd2, 32'd0);
      tick();
      lk(5'd2, 32'd5);
      tick();
      // saturation: 65537 x FFFF reaches exactly all-ones without saturating
      cxl(5'd9, 16'hFFFF);
      for (int i = 0; i < 65537; i++) tick();
      bus.cancel_valid = 1'b0;
      tick();
      lk(5'd9, 32'hFFFF_FFFF);
      tick();
      chk("sat_exact_max", {31'b0, bus.sat_flag}, 32'd0);
      cxl(5'd9, 16'hFFFF);
      tick();
      bus.cancel_valid = 1'b0;
      lk(5'd9, 32'hFFFF_FFFF);
      tick();
      chk("sat_set", {31'b0, bus.sat_flag}, 32'd1);
      bus.clear_all = 1'b1;
      tick();
      chk("sat_cleared", {31'b0, bus.sat_flag}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         chk("clrall_busy", {31'b0, bus.init_busy}, 32'd1);
         tick();
      end
      chk("clrall_done", {31'b0, bus.init_busy}, 32'd0);
      lk(5'd9, 32'd0);
      tick();
      // clear_all in the middle of a sweep restarts it
      bus.clear_all = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) tick();
      bus.clear_all = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         chk("mid_busy", {31'b0, bus.init_busy}, 32'd1);
         chk("mid_ready", {31'b0, bus.cancel_ready}, 32'd0);
         tick();
      end
      chk("mid_done", {31'b0, bus.init_busy}, 32'd0);
      chk("mid_ready_up", {31'b0, bus.cancel_ready}, 32'd1);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
